// File: rtl/hilo_div_if.sv
// Execute-stage <-> divide sequencer handshake bundle.
// The execute stage is the master; the divider is the slave.
interface hilo_div_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic             signedE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             annulE;
  logic             stallE;
  logic             busy;
  logic             validE;
  logic [WIDTH-1:0] hiE;
  logic [WIDTH-1:0] loE;

  modport master (
    output startE, signedE, srcaE, srcbE, annulE,
    input  stallE, busy, validE, hiE, loE
  );

  modport slave (
    input  startE, signedE, srcaE, srcbE, annulE,
    output stallE, busy, validE, hiE, loE
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// Radix-2 restoring divide sequencer for the HI/LO path.
// Results: quotient on loE, remainder on hiE.
module hilo_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic       clk,
  input logic       rst,
  hilo_div_if.slave io
);
  typedef enum logic [1:0] {
    IDLE, CALC, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             valid_q, valid_d;

  logic             a_neg, b_neg, ge;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_n, quot_n;
  logic [WIDTH:0]   rem_sh, dvsr_x, diff;

  always_comb begin
    a_neg = io.signedE & io.srcaE[WIDTH-1];
    b_neg = io.signedE & io.srcbE[WIDTH-1];
    a_mag = a_neg ? -io.srcaE : io.srcaE;
    b_mag = b_neg ? -io.srcbE : io.srcbE;

    // Extra bit keeps the shifted remainder exact for large divisors
    rem_sh = {rem_q, quot_q[WIDTH-1]};
    dvsr_x = {1'b0, dvsr_q};
    diff   = rem_sh - dvsr_x;
    ge     = rem_sh >= dvsr_x;
    rem_n  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quot_n = {quot_q[WIDTH-2:0], ge};

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (io.startE) begin
          if (io.srcbE == '0) begin
            lo_d    = '1;
            hi_d    = io.srcaE;
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            quot_d  = a_mag;
            dvsr_d  = b_mag;
            rem_d   = '0;
            rneg_d  = a_neg;
            qneg_d  = a_neg ^ b_neg;
            cnt_d   = CNT_W'(WIDTH);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d  = rem_n;
        quot_d = quot_n;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          lo_d    = qneg_q ? -quot_n : quot_n;
          hi_d    = rneg_q ? -rem_n : rem_n;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A flush wins over issue and over the final step
    if (io.annulE) begin
      state_d = IDLE;
      valid_d = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      valid_q <= valid_d;
    end
  end

  assign io.busy   = (state_q == CALC);
  assign io.stallE = (state_q == IDLE & io.startE & ~io.annulE)
                   | (state_q == CALC);
  assign io.validE = valid_q;
  assign io.hiE    = hi_q;
  assign io.loE    = lo_q;
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: vector table plus
// annul, reset and back-to-back sequences.
module tb_hilo_div_ctrl;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cyc;
  int   vcyc;

  hilo_div_if #(.WIDTH(32)) io ();

  hilo_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    int          stall;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic run_div(input logic sg,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] elo,
                         input logic [31:0] ehi,
                         input int estall,
                         input string nm);
    int st;
    bit seen;
    st = 0;
    seen = 0;
    @(negedge clk);
    io.startE  = 1'b1;
    io.signedE = sg;
    io.srcaE   = a;
    io.srcbE   = b;
    for (int i = 0; i < 100 && !seen; i++) begin
      #1;
      if (io.validE) begin
        seen = 1;
        vcyc = cyc;
        chk({nm, " lo"}, io.loE, elo);
        chk({nm, " hi"}, io.hiE, ehi);
        chk({nm, " stall"}, 32'(st), 32'(estall));
        chk({nm, " stall in done"}, 32'(io.stallE), 32'd0);
        io.startE = 1'b0;
      end else begin
        if (io.stallE) st++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no validE required validE", nm);
      io.startE = 1'b0;
    end
  endtask

  logic [31:0] plo, phi;
  int vcnt, v1;

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    vcyc = 0;
    rst = 1'b1;
    io.startE  = 1'b0;
    io.signedE = 1'b0;
    io.srcaE   = '0;
    io.srcbE   = '0;
    io.annulE  = 1'b0;

    tv[0]  = '{1'b0, 32'd7,        32'd2,        32'h3,        32'h1,        33};
    tv[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    tv[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1,        33};
    tv[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        33};
    tv[4]  = '{1'b0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        33};
    tv[5]  = '{1'b0, 32'h12345678, 32'h0,        32'hFFFFFFFF, 32'h12345678, 1};
    tv[6]  = '{1'b1, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1};
    tv[7]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        33};
    tv[8]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 33};
    tv[9]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h1,        32'h0,        33};
    tv[10] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'h0,        33};
    tv[11] = '{1'b0, 32'd5,        32'd9,        32'h0,        32'd5,        33};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset validE", 32'(io.validE), 32'd0);
    chk("reset busy", 32'(io.busy), 32'd0);
    chk("reset stallE", 32'(io.stallE), 32'd0);
    chk("reset hiE", io.hiE, 32'd0);
    chk("reset loE", io.loE, 32'd0);

    for (int k = 0; k < 12; k++) begin
      run_div(tv[k].sg, tv[k].a, tv[k].b,
              tv[k].lo, tv[k].hi, tv[k].stall,
              $sformatf("vec%0d", k));
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d valid one cycle", k),
          32'(io.validE), 32'd0);
    end
    plo = 32'h0;
    phi = 32'd5;

    // annul on CALC cycle 10
    @(negedge clk);
    io.startE = 1'b1;
    io.signedE = 1'b0;
    io.srcaE = 32'd100;
    io.srcbE = 32'd7;
    repeat (10) @(negedge clk);
    io.annulE = 1'b1;
    io.startE = 1'b0;
    #1;
    chk("annul busy before", 32'(io.busy), 32'd1);
    @(negedge clk);
    io.annulE = 1'b0;
    #1;
    chk("annul busy", 32'(io.busy), 32'd0);
    chk("annul stallE", 32'(io.stallE), 32'd0);
    chk("annul validE", 32'(io.validE), 32'd0);
    chk("annul hiE held", io.hiE, phi);
    chk("annul loE held", io.loE, plo);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (io.validE) vcnt++;
    end
    chk("annul no validE", 32'(vcnt), 32'd0);
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "post annul");

    // reset on CALC cycle 20
    @(negedge clk);
    io.startE = 1'b1;
    io.signedE = 1'b0;
    io.srcaE = 32'hFFFFFFFF;
    io.srcbE = 32'h10;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    io.startE = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst busy", 32'(io.busy), 32'd0);
    chk("midrst stallE", 32'(io.stallE), 32'd0);
    chk("midrst validE", 32'(io.validE), 32'd0);
    chk("midrst hiE", io.hiE, 32'd0);
    chk("midrst loE", io.loE, 32'd0);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (io.validE) vcnt++;
    end
    chk("midrst no validE", 32'(vcnt), 32'd0);

    // back-to-back
    run_div(1'b0, 32'd7, 32'd2, 32'h3, 32'h1, 33, "b2b first");
    v1 = vcyc;
    run_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
            32'd14, 32'hFFFFFFFE, 33, "b2b second");
    chk("b2b gap", 32'(vcyc - v1 - 1), 32'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
